fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Holds the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a 2-entry queue and presents them with their PC to the decode stage over a valid/ready handshake.
- Accepts jump/branch redirects from the resolving stage and discards wrong-path instructions.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  single clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  byte address of the requested word; always word-aligned
imem_gnt  input  1  memory accepts the request this cycle (when imem_req=1)
imem_rvalid  input  1  read data valid; at most one response per granted request, ≥1 cycle after gnt
imem_rdata  input  32  instruction word
inst_valid  output  1  inst/inst_pc hold a valid instruction
inst_ready  input  1  decode stage consumes inst this cycle
inst  output  32  instruction word (`WORD) to the decoder
inst_pc  output  32  address of inst
redirect  input  1  jump/branch taken; flush and refetch
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced to 0)

Behaviour:
- Reset values:
  - pc=RESET_PC, state=S_REQ, queue empty.
  - inst_valid=0, inst=0, inst_pc=0.
  - imem_req=0 in the reset cycle; it asserts on the first cycle after reset deasserts.
- Only one memory request may be outstanding at a time.
- Credit rule: imem_req=1 only in S_REQ, and only when (queue count + outstanding) < 2. This guarantees a returning word always has a free slot.
- imem_addr = pc at all times.
  - pc changes only on a grant (pc+4, 32-bit wrap 0xFFFF_FFFC→0) or on a redirect.
- States:
  - S_REQ: on imem_req & imem_gnt, record the request pc and go to S_WAIT. Any imem_rvalid arriving in S_REQ is ignored.
  - S_WAIT: on imem_rvalid, push {request pc, imem_rdata} into the queue and go to S_REQ. The next request may issue in the following cycle (no same-cycle chaining).
  - S_DROP: a killed request is outstanding. On imem_rvalid, discard the data and go to S_REQ.
- Redirect (highest priority over every other event in the same cycle):
  - pc ← {redirect_pc[31:2],2'b00}.
  - Queue flushed; inst_valid=0 next cycle.
  - State transitions on redirect:
    - S_REQ with no gnt that cycle → stay in S_REQ.
    - S_REQ with gnt that same cycle → S_DROP.
    - S_WAIT without rvalid that cycle → S_DROP.
    - S_WAIT with rvalid that cycle → data discarded, go to S_REQ.
    - S_DROP without rvalid → stay in S_DROP.
    - S_DROP with rvalid → go to S_REQ.
  - A redirect in the same cycle as inst_ready: the pop is irrelevant; the flush wins.
- Output queue:
  - 2-entry FIFO with registered outputs. inst_valid = (count≠0); inst/inst_pc show the head entry.
  - A push into an empty queue becomes visible on inst_valid the next cycle (latency rvalid→inst_valid = 1 cycle).
  - Pop when inst_valid & inst_ready. Push and pop in the same cycle are allowed; count is unchanged.
  - inst/inst_pc hold their value while inst_valid=1 and inst_ready=0.
- Reset mid-operation returns to the reset state. A stale imem_rvalid seen after reset (in S_REQ) is ignored.
- Throughput with gnt=1 and rvalid one cycle later: one instruction every 2 cycles.

Decomposition:
- Shared defines (existing defines file):
  - state encoding S_REQ/S_WAIT/S_DROP (2 bits)
  - `PC_STEP (32'd4)
  - reuse of `WORD for inst/rdata widths
- Sub-module: fetch_buf, the 2-entry {pc,inst} FIFO with push/pop/flush and count output. fetch_unit holds the PC, FSM and credit logic.

Test Plan:
1. Reset, then release with gnt held at 1 → the first cycle shows imem_req=1, imem_addr=0x0; inst_valid stays 0 until the first rvalid.
2. Streaming: gnt=1, rvalid one cycle after gnt, data 0xA0,0xA4,0xA8, inst_ready=1 → decoder sees (pc,inst) = (0,0xA0), (4,0xA4), (8,0xA8) in order, one every 2 cycles.
3. Backpressure: inst_ready=0 → after two words are queued, imem_req stays 0 with imem_addr=0x8 and inst holds 0xA0. Raise inst_ready → pops 0xA0 then 0xA4; fetch resumes at 0x8.
4. Redirect in S_WAIT: redirect_pc=0x103, then rvalid with 0xDEAD → 0xDEAD never appears on inst; the next request has addr=0x100; inst_valid=0 the cycle after redirect.
5. Redirect in the same cycle as gnt and inst_ready, with 1 entry queued → queue empty next cycle, state S_DROP; the next rvalid is discarded, then a request issues at the new pc.
6. PC wrap: RESET_PC=0xFFFF_FFFC → second request addr=0x0000_0000. Also: assert reset during S_WAIT, then a late rvalid → ignored; addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch stage.
// Word width, PC step, FSM state encoding and the {pc, inst} queue entry.
package fetch_unit_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   typedef struct packed {
      word_t pc;
      word_t inst;
   } entry_t;

   function automatic word_t align_word(input word_t a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem req/gnt/rvalid bus, decode valid/ready bus and redirect.
// master = fetch stage side, slave = memory/decode/resolve environment side.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic  imem_req;
   word_t imem_addr;
   logic  imem_gnt;
   logic  imem_rvalid;
   word_t imem_rdata;
   logic  inst_valid;
   logic  inst_ready;
   word_t inst;
   word_t inst_pc;
   logic  redirect;
   word_t redirect_pc;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output inst_valid, inst, inst_pc,
      input  inst_ready,
      input  redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  inst_valid, inst, inst_pc,
      output inst_ready,
      output redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry {pc, inst} FIFO with registered head, push/pop/flush.
// Ports: clk, reset, flush, push, wdata, pop -> valid, head, count.
module fetch_buf
   import fetch_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  entry_t     wdata,
   input  logic       pop,
   output logic       valid,
   output entry_t     head,
   output logic [1:0] count
);

   entry_t     head_q, head_d;
   entry_t     tail_q, tail_d;
   logic [1:0] count_q, count_d;

   // head_q is always the oldest entry, so outputs come straight from flops
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) head_d = wdata;
               else                 tail_d = wdata;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = wdata;
               end else begin
                  head_d = tail_q;
                  tail_d = wdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign valid = (count_q != 2'd0);
   assign head  = head_q;
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, request FSM and credit logic feeding a 2-entry inst queue.
// Ports: clk, reset, bus (fetch_unit_if.master: imem, decode, redirect).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000
)
(
   input  logic clk,
   input  logic reset,
   fetch_unit_if.master bus
);

   state_t     state_q, state_d;
   word_t      pc_q, pc_d;
   word_t      req_pc_q, req_pc_d;
   logic [1:0] count;
   logic       outstanding;
   logic       credit_ok;
   logic       req;
   logic       fire;
   logic       push;
   logic       pop;
   logic       valid;
   entry_t     head;

   // a word in flight already owns a queue slot
   assign outstanding = (state_q != S_REQ);
   assign credit_ok   = ({1'b0, count} + {2'b00, outstanding}) < 3'd2;
   assign req         = ~reset & (state_q == S_REQ) & credit_ok;
   assign fire        = req & bus.imem_gnt;
   assign pop         = valid & bus.inst_ready;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      unique case (state_q)
         S_REQ: begin
            if (fire) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + PC_STEP;
               state_d  = bus.redirect ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               push    = ~bus.redirect;
               state_d = S_REQ;
            end else if (bus.redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (bus.imem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
      if (bus.redirect) pc_d = align_word(bus.redirect_pc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   fetch_buf u_buf (
      .clk   (clk),
      .reset (reset),
      .flush (bus.redirect),
      .push  (push),
      .wdata ('{pc: req_pc_q, inst: bus.imem_rdata}),
      .pop   (pop),
      .valid (valid),
      .head  (head),
      .count (count)
   );

   assign bus.imem_req   = req;
   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = valid;
   assign bus.inst       = head.inst;
   assign bus.inst_pc    = head.pc;

endmodule
